result_uart_tx: RTL and testbench
=================================

RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per UART bit; legal range 2..65535.
REQ-002 The block SHALL have parameter HEADER, default 8'hA5: sync byte sent first in every frame.
REQ-003 The block SHALL have port CLK  input  1  the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port RES_DATA  input  16  result word to transmit; sampled only on acceptance.
REQ-006 The block SHALL have port RES_VALID  input  1  source holds high while RES_DATA is valid.
REQ-007 The block SHALL have port RES_READY  output  1  high when a new word can be accepted.
REQ-008 The block SHALL have port TXD  output  1  UART serial line, 8N1, idle high.
REQ-009 The block SHALL have port BUSY  output  1  high while a frame is in flight.
REQ-010 The block SHALL have port FRAME_DONE  output  1  one-cycle pulse at frame completion.

Function
REQ-011 Acceptance SHALL occur on a rising edge where RES_VALID=1 and RES_READY=1; RES_DATA is latched into an internal register on that edge.
REQ-012 RES_READY SHALL be 1 only in state IDLE; RES_VALID while BUSY=1 SHALL be ignored, not queued.
REQ-013 A frame SHALL be three bytes in order: HEADER, RES_DATA[15:8], RES_DATA[7:0].
REQ-014 Each byte SHALL be one start bit (0), eight data bits LSB first, one stop bit (1); no idle gap between bytes.
REQ-015 Every bit SHALL be held on TXD for exactly CLKS_PER_BIT cycles; a frame lasts exactly 30*CLKS_PER_BIT cycles.
REQ-016 State machine SHALL have states IDLE, START, DATA, STOP, with a 2-bit byte index (0..2) and a 3-bit bit index (0..7).
REQ-017 Transitions: IDLE->START on acceptance; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after bit 7 completes; STOP->START if byte index<2 (index incremented), else STOP->IDLE.
REQ-018 If acceptance occurs on edge k, TXD SHALL be 0 and BUSY 1 and RES_READY 0 from edge k; data bit i of byte j SHALL be driven from edge k+(10j+1+i)*CLKS_PER_BIT.
REQ-019 On edge k+30*CLKS_PER_BIT the block SHALL enter IDLE, with BUSY=0, RES_READY=1 and FRAME_DONE=1 for exactly one cycle; TXD SHALL remain 1.
REQ-020 Earliest next acceptance SHALL be edge k+30*CLKS_PER_BIT+1; back-to-back frames therefore have one idle-high cycle between them.
REQ-021 Changes on RES_DATA after acceptance SHALL NOT affect the frame in flight.
REQ-022 TXD SHALL be driven directly from a flip-flop (glitch-free, no combinational path from inputs).
REQ-023 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload to 0 at each bit boundary; it SHALL NOT wrap mid-bit.

Reset
REQ-024 While RESET=0: TXD=1, RES_READY=0, BUSY=0, FRAME_DONE=0, state IDLE, all counters and the data register 0.
REQ-025 Reset assertion mid-frame SHALL force TXD to 1 immediately (asynchronously) and abandon the frame; no FRAME_DONE is produced.
REQ-026 RES_READY SHALL rise on the first rising edge after RESET deasserts.

Verification (CLKS_PER_BIT=4)
REQ-027 Accept 16'h1234 -> TXD carries 0xA5, 0x12, 0x34 as 8N1 LSB-first, each bit 4 cycles wide; FRAME_DONE pulses on edge accept+120.
REQ-028 RES_VALID held high continuously with 16'h00FF then 16'hFF00 -> two frames; the second start bit begins exactly 121 cycles after the first; the second frame carries 0xA5, 0xFF, 0x00.
REQ-029 RES_VALID pulsed with 16'hBEEF on cycle 10 of a frame in flight -> the word is ignored; the in-flight frame is unchanged; no second frame.
REQ-030 Accept 16'hFFFF, then change RES_DATA to 16'h0000 one cycle later -> the frame still carries 0xA5, 0xFF, 0xFF.
REQ-031 Assert RESET on cycle 50 of a frame -> TXD=1 within the same cycle, BUSY=0, no FRAME_DONE; after release, RES_READY=1 on the next edge and a new frame of 16'h0001 transmits correctly.
REQ-032 A UART receiver model at the same bit rate SHALL decode all frames in scenarios REQ-027..REQ-031 with no framing errors.

Source files
------------

// File: rtl/result_uart_tx.sv
// Purpose : frames a 16-bit result word as three 8N1 UART bytes (HEADER, hi, lo) on TXD.
// Latency : TXD drops to the start bit on the accepting edge; the frame lasts 30*CLKS_PER_BIT cycles.
// Backpr. : RES_READY is high only when idle; RES_VALID while a frame is in flight is ignored, not queued.
//
// Ports:
//   CLK        system clock, rising-edge active
//   RESET      asynchronous active-low reset
//   RES_DATA   result word, captured on the accepting edge
//   RES_VALID  source-side valid
//   RES_READY  block can accept a word this cycle
//   TXD        UART serial output, idle high, registered
//   BUSY       a frame is in flight
//   FRAME_DONE one-cycle pulse when the last stop bit has completed

module result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] RES_DATA,
  input  logic        RES_VALID,
  output logic        RES_READY,
  output logic        TXD,
  output logic        BUSY,
  output logic        FRAME_DONE
);

  // Counter only needs to reach CLKS_PER_BIT-1; keep at least one bit.
  localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [15:0]      data_q, data_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;
  logic             armed_q;

  logic             accept;
  logic             bit_last;
  logic [2:0]       nxt_bit;
  logic [7:0]       cur_byte;

  // armed_q holds RES_READY low through reset and lets it rise on the
  // first clock edge after release, even though the FSM already sits in IDLE.
  assign RES_READY  = armed_q && (state_q == IDLE);
  assign BUSY       = (state_q != IDLE);
  assign TXD        = txd_q;
  assign FRAME_DONE = done_q;

  assign accept   = RES_VALID && RES_READY;
  assign bit_last = (cnt_q == CNT_LAST);
  assign nxt_bit  = bit_idx_q + 3'd1;

  // Byte currently being shifted out; uses only the captured word so the
  // source may change RES_DATA freely once the word has been accepted.
  always_comb begin
    cur_byte = HEADER;
    case (byte_idx_q)
      2'd0:    cur_byte = HEADER;
      2'd1:    cur_byte = data_q[15:8];
      default: cur_byte = data_q[7:0];
    endcase
  end

  // Next-state logic. txd_d is the value TXD will show after the edge, so
  // each transition loads the first level of the bit it enters.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    data_d     = data_q;
    txd_d      = txd_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d      = 1'b1;
        cnt_d      = '0;
        bit_idx_d  = 3'd0;
        byte_idx_d = 2'd0;
        if (accept) begin
          data_d  = RES_DATA;
          state_d = START;
          txd_d   = 1'b0;
        end
      end

      START: begin
        if (bit_last) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
          txd_d     = cur_byte[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_last) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = nxt_bit;
            txd_d     = cur_byte[nxt_bit];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (bit_last) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          if (byte_idx_q < 2'd2) begin
            // No idle gap: the next start bit follows the stop bit directly.
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
            txd_d      = 1'b0;
          end else begin
            byte_idx_d = 2'd0;
            state_d    = IDLE;
            txd_d      = 1'b1;
            done_d     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      data_q     <= 16'h0000;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      data_q     <= data_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
      armed_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Purpose : self-checking bench for result_uart_tx at four clocks per bit.
// Latency : expected line levels come from an offset-from-acceptance model.
// Backpr. : drives RES_VALID/RES_DATA directly; a UART receiver decodes TXD.

module tb_result_uart_tx;

  localparam int         C   = 4;
  localparam logic [7:0] HDR = 8'hA5;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic [15:0] res_data  = 16'h0000;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic        txd;
  logic        busy;
  logic        frame_done;

  int n_cmp      = 0;
  int n_bad      = 0;
  int cyc        = 0;
  int rx_ferr    = 0;
  int last_start = 0;
  logic [7:0] rx_q[$];

  result_uart_tx #(
    .CLKS_PER_BIT(C),
    .HEADER      (HDR)
  ) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .RES_DATA  (res_data),
    .RES_VALID (res_valid),
    .RES_READY (res_ready),
    .TXD       (txd),
    .BUSY      (busy),
    .FRAME_DONE(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line level t cycles after the accepting edge: 30 bit slots of C cycles,
  // ten slots per byte (start, 8 data LSB first, stop).
  function automatic logic exp_txd(input logic [15:0] d, input int t);
    int b, j, p;
    logic [7:0] by;
    if (t >= 30 * C) return 1'b1;
    b  = t / C;
    j  = b / 10;
    p  = b % 10;
    by = (j == 0) ? HDR : (j == 1) ? d[15:8] : d[7:0];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return by[p-1];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // UART receiver: samples mid-bit on falling clock edges, discards any byte
  // overlapped by reset, and counts framing errors.
  initial begin
    logic [7:0] b;
    logic       ferr;
    logic       saw_rst;
    forever begin
      @(negedge txd);
      if (!rst_n) continue;
      saw_rst = 1'b0;
      ferr    = 1'b0;
      repeat (C / 2) @(negedge clk);
      if (!rst_n) saw_rst = 1'b1;
      if (txd !== 1'b0) ferr = 1'b1;
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge clk);
        if (!rst_n) saw_rst = 1'b1;
        b[i] = txd;
      end
      repeat (C) @(negedge clk);
      if (!rst_n) saw_rst = 1'b1;
      if (txd !== 1'b1) ferr = 1'b1;
      if (!saw_rst) begin
        rx_q.push_back(b);
        if (ferr) rx_ferr++;
      end
    end
  end

  // Offer a word and return at the falling edge just after acceptance.
  task automatic accept(input logic [15:0] d);
    int n = 0;
    res_data  = d;
    res_valid = 1'b1;
    while (res_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", res_ready, 1);
    @(negedge clk);
  endtask

  // Checks every cycle of a frame from t=0 (first falling edge after
  // acceptance) to t=30*C. Optional mid-frame valid pulse and reset abort.
  task automatic run_frame(input logic [15:0] d, input int poke_t,
                           input logic [15:0] poke_d, input int abort_t);
    last_start = cyc;
    for (int t = 0; t <= 30 * C; t++) begin
      if (t > 0) @(negedge clk);
      if (poke_t >= 0 && t == poke_t) begin
        res_valid = 1'b1;
        res_data  = poke_d;
      end
      if (poke_t >= 0 && t == poke_t + 1) res_valid = 1'b0;
      if (t == abort_t) begin
        rst_n = 1'b0;
        #1;
        check("txd_async_reset", txd, 1);
        check("busy_async_reset", busy, 0);
        check("done_async_reset", frame_done, 0);
        return;
      end
      check($sformatf("txd t=%0d", t), txd, exp_txd(d, t));
      check($sformatf("busy t=%0d", t), busy, (t < 30 * C));
      check($sformatf("ready t=%0d", t), res_ready, (t == 30 * C));
      check($sformatf("done t=%0d", t), frame_done, (t == 30 * C));
    end
  endtask

  task automatic idle_check(input int n, input logic exp_rdy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_txd", txd, 1);
      check("idle_busy", busy, 0);
      check("idle_done", frame_done, 0);
      check("idle_ready", res_ready, exp_rdy);
    end
  endtask

  task automatic check_rx(input logic [15:0] d);
    logic [7:0] want[3];
    logic [8:0] got;
    want[0] = HDR;
    want[1] = d[15:8];
    want[2] = d[7:0];
    check("rx_count", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (rx_q.size() > 0) got = {1'b0, rx_q.pop_front()};
      else                 got = 9'h1FF;
      check($sformatf("rx_byte%0d", i), got, {1'b0, want[i]});
    end
    rx_q.delete();
  endtask

  initial begin
    logic [15:0] w;
    int s1, s2, gap, pt;

    // Reset values and ready rising on the first edge after release.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_ready", res_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    rst_n = 1'b1;
    check("ready_at_release", res_ready, 0);
    @(negedge clk);
    check("ready_first_edge", res_ready, 1);
    idle_check(2, 1'b1);

    // Single frame of 0x1234.
    accept(16'h1234);
    res_valid = 1'b0;
    run_frame(16'h1234, -1, 16'h0000, -1);
    check_rx(16'h1234);
    idle_check(3, 1'b1);

    // Valid held high: two frames back to back, one idle cycle between.
    accept(16'h00FF);
    res_data = 16'hFF00;
    run_frame(16'h00FF, -1, 16'h0000, -1);
    s1 = last_start;
    check_rx(16'h00FF);
    @(negedge clk);
    res_valid = 1'b0;
    run_frame(16'hFF00, -1, 16'h0000, -1);
    s2 = last_start;
    check("b2b_start_gap", s2 - s1, 30 * C + 1);
    check_rx(16'hFF00);
    idle_check(3, 1'b1);

    // Valid pulsed mid-frame is ignored and not queued.
    accept(16'h5A3C);
    res_valid = 1'b0;
    run_frame(16'h5A3C, 10, 16'hBEEF, -1);
    check_rx(16'h5A3C);
    idle_check(40, 1'b1);
    check("no_extra_rx", rx_q.size(), 0);

    // Data changed right after acceptance does not alter the frame.
    accept(16'hFFFF);
    res_valid = 1'b0;
    res_data  = 16'h0000;
    run_frame(16'hFFFF, -1, 16'h0000, -1);
    check_rx(16'hFFFF);
    idle_check(2, 1'b1);

    // Reset mid-frame abandons the frame; recovery sends a clean frame.
    accept(16'hC3C3);
    res_valid = 1'b0;
    run_frame(16'hC3C3, -1, 16'h0000, 50);
    idle_check(6, 1'b0);
    rst_n = 1'b1;
    check("ready_after_rst_release", res_ready, 0);
    @(negedge clk);
    check("ready_edge_after_rst", res_ready, 1);
    idle_check(40, 1'b1);
    rx_q.delete();
    accept(16'h0001);
    res_valid = 1'b0;
    run_frame(16'h0001, -1, 16'h0000, -1);
    check_rx(16'h0001);
    idle_check(2, 1'b1);

    // Random words, random idle gaps, random ignored mid-frame pulses.
    for (int i = 0; i < 5; i++) begin
      w   = 16'($urandom);
      gap = int'($urandom_range(0, 6));
      pt  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 110)) : -1;
      repeat (gap) @(negedge clk);
      accept(w);
      res_valid = 1'b0;
      run_frame(w, pt, 16'($urandom), -1);
      check_rx(w);
      idle_check(1, 1'b1);
    end

    check("rx_framing_errors", rx_ferr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
